// File: rtl/cd_mesh_pkg.sv
// Shared mesh definitions: flit width, LLC count and the LLC-select field position.
package cd_mesh_pkg;

  localparam int unsigned CD_DATA_W  = 64;
  localparam int unsigned N_LLC      = 4;
  localparam int unsigned LLC_SEL_W  = 2;
  localparam int unsigned CD_LLC_LSB = 6;

  typedef logic [N_LLC-1:0] llc_dst_t;

  // One-hot LLC target from the 2-bit select field.
  function automatic llc_dst_t llc_onehot(input logic [LLC_SEL_W-1:0] sel);
    return llc_dst_t'(1) << sel;
  endfunction

endpackage

// File: rtl/cd_sync_fifo.sv
// Synchronous FIFO with registered storage, wrapping pointers and explicit occupancy.
module cd_sync_fifo #(
  parameter int unsigned WIDTH = 68,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage, pointers and occupancy; everything clears on reset so stale entries never resurface.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        occ <= occ + OCC_W'(1);
      end else if (pop && !push) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

  // Head entry comes straight from the storage registers.
  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/cd_xbar_req_ingress.sv
// Crossbar request ingress: buffers upstream flits, tags each with its one-hot LLC
// target at enqueue, and tracks how long the head has been stalled.
module cd_xbar_req_ingress
  import cd_mesh_pkg::*;
#(
  parameter int unsigned DATA_W    = CD_DATA_W,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LLC_LSB   = CD_LLC_LSB,
  parameter int unsigned STALL_MAX = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     up_si,
  output logic                     up_ri,
  input  logic [DATA_W-1:0]        up_di,
  output logic                     xb_so,
  input  logic                     xb_ro,
  output logic [DATA_W-1:0]        xb_do,
  output logic [N_LLC-1:0]         xb_dst,
  output logic [$clog2(DEPTH):0]   occ,
  output logic [7:0]               hol_stall,
  output logic                     hol_timeout
);

  localparam int unsigned OCC_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = DATA_W + N_LLC;

  logic               push;
  logic               pop;
  llc_dst_t           wr_dst;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // Handshakes depend only on registered occupancy, never on xb_ro.
  assign up_ri = reset && (occ < OCC_W'(DEPTH));
  assign xb_so = (occ != '0);
  assign push  = up_si && up_ri;
  assign pop   = xb_so && xb_ro;

  // Decode the target once at enqueue and store it alongside the flit.
  assign wr_dst   = llc_onehot(up_di[LLC_LSB +: LLC_SEL_W]);
  assign wr_entry = {wr_dst, up_di};
  assign {xb_dst, xb_do} = rd_entry;

  cd_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .occ   (occ)
  );

  // Head-of-line stall counter: clears on pop, saturates while the head waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hol_stall <= '0;
    end else if (pop) begin
      hol_stall <= '0;
    end else if (xb_so && !xb_ro && (hol_stall != 8'(STALL_MAX))) begin
      hol_stall <= hol_stall + 8'd1;
    end
  end

  assign hol_timeout = (hol_stall == 8'(STALL_MAX));

endmodule

// File: tb/tb_cd_xbar_req_ingress.sv
// Bench for cd_xbar_req_ingress: fixed vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_cd_xbar_req_ingress;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int SMAX  = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          up_si;
  logic          up_ri;
  logic [DW-1:0] up_di;
  logic          xb_so;
  logic          xb_ro;
  logic [DW-1:0] xb_do;
  logic [3:0]    xb_dst;
  logic [2:0]    occ;
  logic [7:0]    hol_stall;
  logic          hol_timeout;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of flits plus an integer stall count.
  logic [DW-1:0] mq[$];
  int            mstall;

  always #5 clk = ~clk;

  cd_xbar_req_ingress dut (
    .clk         (clk),
    .reset       (reset),
    .up_si       (up_si),
    .up_ri       (up_ri),
    .up_di       (up_di),
    .xb_so       (xb_so),
    .xb_ro       (xb_ro),
    .xb_do       (xb_do),
    .xb_dst      (xb_dst),
    .occ         (occ),
    .hol_stall   (hol_stall),
    .hol_timeout (hol_timeout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] dst_of(input logic [DW-1:0] d);
    int sel;
    sel = int'(d[7:6]);
    return 4'(2 ** sel);
  endfunction

  // Compare every DUT output with the model's view of the queue.
  task automatic check_model(input string tag);
    chk({tag, ".occ"}, 64'(occ), 64'(mq.size()));
    chk({tag, ".xb_so"}, 64'(xb_so), 64'(mq.size() != 0));
    chk({tag, ".up_ri"}, 64'(up_ri), 64'(mq.size() < DEPTH));
    chk({tag, ".hol_stall"}, 64'(hol_stall), 64'(mstall));
    chk({tag, ".hol_timeout"}, 64'(hol_timeout), 64'(mstall == SMAX));
    if (mq.size() != 0) begin
      chk({tag, ".xb_do"}, xb_do, mq[0]);
      chk({tag, ".xb_dst"}, 64'(xb_dst), 64'(dst_of(mq[0])));
    end
  endtask

  // One clock with the given inputs; model advances from its pre-edge state.
  task automatic cycle(input logic si, input logic [DW-1:0] d, input logic ro, input string tag);
    bit m_push, m_pop;
    up_si = si;
    up_di = d;
    xb_ro = ro;
    m_push = si && (mq.size() < DEPTH);
    m_pop  = (mq.size() != 0) && ro;
    @(posedge clk);
    #1;
    if (m_pop) begin
      void'(mq.pop_front());
      mstall = 0;
    end else if (mq.size() != 0 && !ro) begin
      mstall = (mstall < SMAX) ? mstall + 1 : SMAX;
    end
    if (m_push) mq.push_back(d);
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    up_si = 1'b0;
    xb_ro = 1'b0;
    repeat (2) @(posedge clk);
    mq.delete();
    mstall = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          si;
    logic [DW-1:0] d;
    logic          ro;
    logic [2:0]    e_occ;
    logic          e_so;
    logic [DW-1:0] e_do;
    logic [3:0]    e_dst;
    logic          e_ri;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] first_new;

    vecs[0]  = '{1'b1, 64'hA5A5_0000_0000_0080, 1'b1, 3'd1, 1'b1, 64'hA5A5_0000_0000_0080, 4'b0100, 1'b1};
    vecs[1]  = '{1'b0, 64'h0,                   1'b1, 3'd0, 1'b0, 64'h0,                   4'b0000, 1'b1};
    vecs[2]  = '{1'b1, 64'h1111_0000_0000_0040, 1'b0, 3'd1, 1'b1, 64'h1111_0000_0000_0040, 4'b0010, 1'b1};
    vecs[3]  = '{1'b1, 64'h2222_0000_0000_00C0, 1'b0, 3'd2, 1'b1, 64'h1111_0000_0000_0040, 4'b0010, 1'b1};
    vecs[4]  = '{1'b1, 64'h3333_0000_0000_0000, 1'b0, 3'd3, 1'b1, 64'h1111_0000_0000_0040, 4'b0010, 1'b1};
    vecs[5]  = '{1'b1, 64'h4444_0000_0000_0011, 1'b0, 3'd4, 1'b1, 64'h1111_0000_0000_0040, 4'b0010, 1'b0};
    vecs[6]  = '{1'b1, 64'h5555_0000_0000_0022, 1'b1, 3'd3, 1'b1, 64'h2222_0000_0000_00C0, 4'b1000, 1'b1};
    vecs[7]  = '{1'b1, 64'h5555_0000_0000_0022, 1'b1, 3'd3, 1'b1, 64'h3333_0000_0000_0000, 4'b0001, 1'b1};
    vecs[8]  = '{1'b0, 64'h0,                   1'b1, 3'd2, 1'b1, 64'h4444_0000_0000_0011, 4'b0001, 1'b1};
    vecs[9]  = '{1'b0, 64'h0,                   1'b1, 3'd1, 1'b1, 64'h5555_0000_0000_0022, 4'b0001, 1'b1};
    vecs[10] = '{1'b0, 64'h0,                   1'b1, 3'd0, 1'b0, 64'h0,                   4'b0000, 1'b1};

    reset = 1'b0;
    up_si = 1'b0;
    up_di = '0;
    xb_ro = 1'b0;
    mstall = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.occ", 64'(occ), 64'd0);
    chk("rst.xb_so", 64'(xb_so), 64'd0);
    chk("rst.up_ri", 64'(up_ri), 64'd0);
    chk("rst.hol_stall", 64'(hol_stall), 64'd0);
    chk("rst.hol_timeout", 64'(hol_timeout), 64'd0);
    chk("rst.xb_dst", 64'(xb_dst), 64'd0);
    chk("rst.xb_do", xb_do, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_rel.up_ri", 64'(up_ri), 64'd1);

    // Vector table: single push/pop, fill to full with blocked push, drain in order.
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      up_si = vecs[i].si;
      up_di = vecs[i].d;
      xb_ro = vecs[i].ro;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.occ", i), 64'(occ), 64'(vecs[i].e_occ));
      chk($sformatf("vec%0d.xb_so", i), 64'(xb_so), 64'(vecs[i].e_so));
      chk($sformatf("vec%0d.up_ri", i), 64'(up_ri), 64'(vecs[i].e_ri));
      if (vecs[i].e_so) begin
        chk($sformatf("vec%0d.xb_do", i), xb_do, vecs[i].e_do);
        chk($sformatf("vec%0d.xb_dst", i), 64'(xb_dst), 64'(vecs[i].e_dst));
      end
    end
    up_si = 1'b0;
    xb_ro = 1'b0;

    // Model is now in sync (empty queue, zero stall) for the model-checked sequences.
    do_reset();
    check_model("post_rst");

    // Five pushes with the crossbar blocked: fifth held upstream, then drain in order.
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'h0BAD_0000_0000_0000 | DW'(i * 64 + i), 1'b0, "full_fill");
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h0BAD_0000_0000_0004 | DW'(4 * 64), 1'b0, "full_hold");
    for (int i = 0; i < 7; i++) cycle(1'b0, 64'h0, 1'b1, "full_drain");

    // Steady push+pop at occupancy 2 across several pointer wraps.
    cycle(1'b1, 64'hC0DE_0000_0000_0001, 1'b0, "wrap_fill");
    cycle(1'b1, 64'hC0DE_0000_0000_0042, 1'b0, "wrap_fill");
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 64'hF00D_0000_0000_0000 | DW'($urandom), 1'b1, "wrap_stream");
      chk("wrap.occ2", 64'(occ), 64'd2);
    end
    cycle(1'b0, 64'h0, 1'b1, "wrap_drain");
    cycle(1'b0, 64'h0, 1'b1, "wrap_drain");

    // Head stalled for 300 cycles: counter saturates, timeout asserts, a pop clears it.
    cycle(1'b1, 64'h5747_0000_0000_00C0, 1'b0, "hol_push");
    for (int i = 1; i <= 300; i++) begin
      cycle(1'b0, 64'h0, 1'b0, "hol_wait");
      if (i == 254) chk("hol.pre_sat_timeout", 64'(hol_timeout), 64'd0);
      if (i == 255) chk("hol.sat_timeout", 64'(hol_timeout), 64'd1);
    end
    chk("hol.stall_sat", 64'(hol_stall), 64'd255);
    cycle(1'b0, 64'h0, 1'b1, "hol_pop");
    chk("hol.cleared", 64'(hol_stall), 64'd0);

    // Reset mid-burst with occ=3: outputs clear without a clock, old flits gone.
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'hDEAD_0000_0000_0000 | DW'(i), 1'b0, "mid_fill");
    chk("mid.occ3", 64'(occ), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst.xb_so", 64'(xb_so), 64'd0);
    chk("mid_rst.occ", 64'(occ), 64'd0);
    chk("mid_rst.up_ri", 64'(up_ri), 64'd0);
    up_si = 1'b0;
    mq.delete();
    mstall = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rel.up_ri", 64'(up_ri), 64'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b1, "mid_empty");
    first_new = 64'hBEEF_0000_0000_0080;
    cycle(1'b1, first_new, 1'b0, "mid_new");
    chk("mid_new.xb_do", xb_do, first_new);
    cycle(1'b0, 64'h0, 1'b1, "mid_new_pop");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom};
      cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cd_xbar_req_ingress.md
CD_XBAR_REQ_INGRESS -- requirements
Module: cd_xbar_req_ingress

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter LLC_LSB, default 6, meaning LSB of the 2-bit LLC-select field in the flit.
REQ-004 SHALL have parameter STALL_MAX, default 255, meaning head-of-line stall saturation value.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port up_si  input  1  upstream flit valid.
REQ-008 SHALL have port up_ri  output  1  ready to upstream.
REQ-009 SHALL have port up_di  input  DATA_W  upstream flit.
REQ-010 SHALL have port xb_so  output  1  valid to crossbar request input.
REQ-011 SHALL have port xb_ro  input  1  crossbar ready (that input's in_ri).
REQ-012 SHALL have port xb_do  output  DATA_W  head flit to crossbar.
REQ-013 SHALL have port xb_dst  output  4  one-hot LLC target of head flit, bit k feeds dst_ok.
REQ-014 SHALL have port occ  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have port hol_stall  output  8  saturating head-of-line stall cycle count.
REQ-016 SHALL have port hol_timeout  output  1  high while hol_stall equals STALL_MAX.

Function
REQ-017 SHALL push when up_si and up_ri are both 1 at a rising edge, and pop when xb_so and xb_ro are both 1.
REQ-018 SHALL drive up_ri = reset high and occ < DEPTH, derived from registered state only, with no combinational path from xb_ro.
REQ-019 SHALL drive xb_so = (occ != 0), with xb_do and xb_dst taken from the head entry registers.
REQ-020 SHALL decode xb_dst at enqueue as 1 << up_di[LLC_LSB+1:LLC_LSB] and store it with the flit, so xb_dst is never zero while xb_so=1.
REQ-021 SHALL present a flit pushed at edge N on xb_do/xb_so after edge N, i.e. in cycle N+1; there is no empty bypass.
REQ-022 SHALL keep occ unchanged on simultaneous push and pop when 0 < occ < DEPTH, and write and read in the same cycle without data corruption.
REQ-023 SHALL make full (occ == DEPTH) deassert up_ri, so no push occurs even if a pop happens that cycle; up_ri rises in the cycle after the pop.
REQ-024 SHALL make empty (occ == 0) hold xb_so=0 and leave xb_do at its last value, which is don't-care.
REQ-025 SHALL use read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, with occ as an explicit counter of width log2(DEPTH)+1.
REQ-026 SHALL increment hol_stall by 1 per cycle with xb_so=1 and xb_ro=0, saturating at STALL_MAX.
REQ-027 SHALL clear hol_stall to 0 on every pop, and hold it when xb_so=0.
REQ-028 SHALL ignore up_di and up_si when up_ri=0; there is no drop and no overwrite.

Reset
REQ-029 SHALL on reset low asynchronously set pointers=0, occ=0, hol_stall=0, xb_so=0, up_ri=0, hol_timeout=0, and stored dst entries=0.
REQ-030 SHALL reset data storage only if desired, with xb_do required to be 0 only when DEPTH entries are reset.
REQ-031 SHALL discard all in-flight flits on reset assertion mid-operation, with no pop or push completed on that edge.
REQ-032 SHALL drive up_ri=1 in the first cycle after reset deasserts.

Structure
REQ-033 SHALL place DATA_W default, N_LLC=4, LLC_LSB default and the LLC-select field position in shared package cd_mesh_pkg.
REQ-034 SHALL put the storage in one sub-module, cd_sync_fifo (data+dst width, DEPTH), with decode and stall counter in the top.
REQ-035 SHALL use eight instances per global crossbar, each instance's xb_dst bit k feeding dst_ok[i].

Verification
REQ-036 SHALL cover: push flit with up_di[7:6]=2'b10, xb_ro=1 -> xb_so=1 next cycle, xb_dst=4'b0100, popped, occ back to 0.
REQ-037 SHALL cover: xb_ro=0 and 5 pushes -> 4 accepted, up_ri=0 from the cycle occ=4; 5th flit held upstream; xb_ro=1 drains in order.
REQ-038 SHALL cover: continuous push and pop at occ=2 for 20 cycles -> occ stays 2, order preserved across pointer wrap.
REQ-039 SHALL cover: head valid, xb_ro=0 for 300 cycles -> hol_stall=255, hol_timeout=1 from cycle 255; one pop -> hol_stall=0.
REQ-040 SHALL cover: reset low mid-burst with occ=3 -> xb_so=0, occ=0 immediately without a clock; after release up_ri=1 and old flits never appear.
